divider: RTL and testbench
==========================

# divider

Sequential shift-subtract (restoring) divider, the inverse companion to the shift-add multiplier datapath. Divides a 16-bit unsigned dividend by an 8-bit unsigned divisor, producing an 8-bit quotient and 8-bit remainder over eight clocked iterations. It lets a product register be divided back by its multiplicand, for round-trip self-check, and serves as a general divide unit in the same system.

## Interface
- Parameters: none; widths fixed by package constants.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on a rising edge.
- `start`  in  1  request a division; sampled only when `ready`=1.
- `dividend`  in  16  unsigned numerator; captured on the accepting edge.
- `divisor`  in  8  unsigned denominator; captured on the accepting edge.
- `quotient`  out  8  last result; reset 8'h00.
- `remainder`  out  8  last result; reset 8'h00.
- `ready`  out  1  high in IDLE/DONE; reset 1.
- `done`  out  1  one-cycle pulse when a result (or error) is written; reset 0.
- `err`  out  1  last operation was divide-by-zero or overflow; reset 0; tied 0 without the macro.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE with `start`=1: load A = `dividend[15:8]`, Q = `dividend[7:0]`, M = `divisor`, count = 0, go RUN. DONE with `start`=0 → IDLE.
- RUN iteration (one per edge): shift {A,Q} left 1 into a 9-bit {c,A}; diff = {c,A} − {1'b0,M} (9 bits). If no borrow: A = diff[7:0], Q[0] = 1; else A unchanged (shifted), Q[0] = 0. count++.
- After the 8th iteration (count = 7): `quotient` = Q, `remainder` = A, `err` = 0, go DONE.
- `start` during RUN is ignored; operands are not re-sampled; `dividend`/`divisor` changes after capture have no effect.
- Output registers change only on completion or reset; they hold between operations.
- Valid result only when `dividend[15:8]` < `divisor` (quotient fits 8 bits).

## Timing
- Start accepted on edge k → iterations on edges k+1..k+8 → results and `done`=1 visible after edge k+8; `ready` = 0 for the cycles after edges k..k+7.
- Back-to-back: `start` held in DONE is accepted immediately; throughput 9 cycles/operation.
- `reset` and `start` on the same edge: reset wins.
- `reset` mid-RUN: IDLE next cycle, outputs to reset values, partial result discarded.

## Configuration
- `DIVIDER_ERRCHK_EN` defined: on the accepting edge, if `divisor` = 0 or `dividend[15:8]` ≥ `divisor`, skip RUN: go DONE directly, `quotient` = 8'hFF, `remainder` = 8'hFF, `err` = 1, `done` pulses after edge k (1-cycle latency).
- Not defined: no check; every start runs 8 iterations; out-of-range results are the raw algorithm output; `err` constant 0.

## Structure
- `divider_pkg`: `N_BITS` = 8, `COUNT_W` = 3, state enum `div_state_t` {IDLE, RUN, DONE}.
- One sub-module `subtractor`: combinational 9-bit minus 8-bit, outputs `diff[7:0]` and `borrow`; mirrors the existing adder.
- Top holds FSM, 3-bit counter, A/Q/M registers, output registers.

## Test plan
- Round trip: `dividend`=16'h2783, `divisor`=8'h55 → `quotient`=8'h77, `remainder`=8'h00, `err`=0, `done` one cycle after edge k+8.
- General: 16'h18E3 / 8'h55 → `quotient`=8'h4A, `remainder`=8'h51; 16'hFEFF / 8'hFF → 8'hFF, 8'hFE.
- Error (macro on): `divisor`=8'h00 → `err`=1, `quotient`=`remainder`=8'hFF, `done` after edge k; 16'h5500 / 8'h55 → same error response.
- `start` pulsed again on edge k+3 with new operands → ignored; result still for the original operands at k+8; `ready` low throughout RUN.
- `reset` asserted after edge k+4 → next cycle IDLE, `ready`=1, `quotient`=`remainder`=8'h00, no `done` pulse.
- Back-to-back: `start` held high through two operations → second accepted in DONE, results at k+8 and k+17.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared widths and FSM state type for the restoring divider.
// DIVIDER_ERRCHK_EN (in divider.sv) enables the divide-by-zero/overflow check.
package divider_pkg;
  localparam int N_BITS     = 8;
  localparam int COUNT_W    = 3;
  localparam int DIVIDEND_W = 2 * N_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/divider_if.sv
// Operand/result bundle between a requester (master) and the divider (slave).
interface divider_if;
  import divider_pkg::*;

  // start is sampled only while ready=1. The cycle in which start=1 and ready=1 at a
  // rising edge captures dividend/divisor. done pulses for one cycle when quotient,
  // remainder and err are updated. Those outputs then hold until the next completion.
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [N_BITS-1:0]     divisor;
  logic [N_BITS-1:0]     quotient;
  logic [N_BITS-1:0]     remainder;
  logic                  ready;
  logic                  done;
  logic                  err;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, ready, done, err
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, ready, done, err
  );
endinterface

// File: rtl/divider_subtractor.sv
// Combinational 9-bit minus 8-bit step used by each restoring-divide iteration.
module subtractor
  import divider_pkg::*;
(
  input  logic [N_BITS:0]   i_a,
  input  logic [N_BITS-1:0] i_b,
  output logic [N_BITS-1:0] o_diff,
  output logic              o_borrow
);
  // Only the low bits of the difference are kept; a borrow means i_a < i_b.
  assign o_borrow = (i_a < {1'b0, i_b});
  assign o_diff   = i_a[N_BITS-1:0] - i_b;
endmodule

// File: rtl/divider.sv
// Sequential shift-subtract (restoring) divider: 16/8 -> 8-bit quotient and remainder.
// Define DIVIDER_ERRCHK_EN to flag divide-by-zero/overflow with a 1-cycle error response.
module divider
  import divider_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  divider_if.slave   bus,
  output div_state_t o_dbg_state
);
  div_state_t          r_state;
  div_state_t          w_next;
  logic [N_BITS-1:0]   r_a;
  logic [N_BITS-1:0]   r_q;
  logic [N_BITS-1:0]   r_m;
  logic [COUNT_W-1:0]  r_count;
  logic [N_BITS-1:0]   r_quotient;
  logic [N_BITS-1:0]   r_remainder;
  logic                r_done;

  logic                w_accept;
  logic                w_bad;
  logic                w_last;
  logic [N_BITS:0]     w_shift;
  logic [N_BITS-1:0]   w_diff;
  logic                w_borrow;
  logic [N_BITS-1:0]   w_a_next;
  logic [N_BITS-1:0]   w_q_next;

  assign w_accept = bus.start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_count == COUNT_W'(N_BITS - 1));

`ifdef DIVIDER_ERRCHK_EN
  logic r_err;
  // Quotient only fits in N_BITS when the high half of the dividend is below the divisor.
  assign w_bad = (bus.divisor == '0) ||
                 (bus.dividend[DIVIDEND_W-1:N_BITS] >= bus.divisor);
`else
  assign w_bad = 1'b0;
`endif

  // {A,Q} shifted left one place; the carry-out of A lands in the 9th bit.
  assign w_shift = {r_a, r_q[N_BITS-1]};

  subtractor u_sub (
    .i_a      (w_shift),
    .i_b      (r_m),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  assign w_a_next = w_borrow ? w_shift[N_BITS-1:0] : w_diff;
  assign w_q_next = {r_q[N_BITS-2:0], ~w_borrow};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = w_bad ? DONE : RUN;
      RUN:  if (w_last)   w_next = DONE;
      DONE: begin
        if (w_accept) w_next = w_bad ? DONE : RUN;
        else          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
`ifdef DIVIDER_ERRCHK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_a     <= bus.dividend[DIVIDEND_W-1:N_BITS];
        r_q     <= bus.dividend[N_BITS-1:0];
        r_m     <= bus.divisor;
        r_count <= '0;
`ifdef DIVIDER_ERRCHK_EN
        if (w_bad) begin
          r_quotient  <= '1;
          r_remainder <= '1;
          r_err       <= 1'b1;
          r_done      <= 1'b1;
        end
`endif
      end else if (r_state == RUN) begin
        r_a     <= w_a_next;
        r_q     <= w_q_next;
        r_count <= r_count + 1'b1;
        if (w_last) begin
          r_quotient  <= w_q_next;
          r_remainder <= w_a_next;
          r_done      <= 1'b1;
`ifdef DIVIDER_ERRCHK_EN
          r_err       <= 1'b0;
`endif
        end
      end
    end
  end

  assign bus.ready     = (r_state != RUN);
  assign bus.done      = r_done;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
`ifdef DIVIDER_ERRCHK_EN
  assign bus.err       = r_err;
`else
  assign bus.err       = 1'b0;
`endif
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: table of hand-computed divisions plus multi-cycle corner sequences.
module tb_divider;
  import divider_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  div_state_t dbg_state;
  divider_if  bus();

  divider dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        err;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int guard = 0;
    @(negedge clock);
    while (!bus.ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    chk({name, "_ready_wait"}, 16'(bus.ready), 16'd1);
  endtask

  task automatic run_op(input string name, input logic [15:0] dvd, input logic [7:0] dvs,
                        input logic [7:0] eq, input logic [7:0] er, input logic ee);
    int lat;
    lat = ee ? 0 : 8;
    wait_ready(name);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clock); #1;
    // Scramble operands after capture; the result must not follow them.
    bus.start    = 1'b0;
    bus.dividend = ~dvd;
    bus.divisor  = ~dvs;
    for (int c = 0; c < lat; c++) begin
      chk({name, "_ready_run"}, 16'(bus.ready), 16'd0);
      chk({name, "_done_early"}, 16'(bus.done), 16'd0);
      @(posedge clock); #1;
    end
    chk({name, "_done"}, 16'(bus.done), 16'd1);
    chk({name, "_quotient"}, 16'(bus.quotient), 16'(eq));
    chk({name, "_remainder"}, 16'(bus.remainder), 16'(er));
    chk({name, "_err"}, 16'(bus.err), 16'(ee));
    chk({name, "_ready_done"}, 16'(bus.ready), 16'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_res;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    vecs.push_back('{16'h2783, 8'h55, 8'h77, 8'h00, 1'b0});
    vecs.push_back('{16'h18E3, 8'h55, 8'h4A, 8'h51, 1'b0});
    vecs.push_back('{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0});
    vecs.push_back('{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0});
    vecs.push_back('{16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0});
    vecs.push_back('{16'h0005, 8'h09, 8'h00, 8'h05, 1'b0});
`ifdef DIVIDER_ERRCHK_EN
    vecs.push_back('{16'h1234, 8'h00, 8'hFF, 8'hFF, 1'b1});
    vecs.push_back('{16'h5500, 8'h55, 8'hFF, 8'hFF, 1'b1});
    vecs.push_back('{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0});
`else
    // Unchecked divide-by-zero: every step succeeds, A ends holding the original low byte.
    vecs.push_back('{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b0});
`endif

    repeat (2) @(posedge clock);
    #1;
    chk("reset_ready", 16'(bus.ready), 16'd1);
    chk("reset_done", 16'(bus.done), 16'd0);
    chk("reset_quotient", 16'(bus.quotient), 16'h00);
    chk("reset_remainder", 16'(bus.remainder), 16'h00);
    chk("reset_err", 16'(bus.err), 16'd0);
    chk("reset_state", 16'(dbg_state), 16'(IDLE));
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].dividend, vecs[i].divisor,
             vecs[i].q, vecs[i].r, vecs[i].err);

    // start re-asserted mid-run with new operands must be ignored.
    wait_ready("midstart");
    bus.start    = 1'b1;
    bus.dividend = 16'h18E3;
    bus.divisor  = 8'h55;
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("midstart_ready_run", 16'(bus.ready), 16'd0);
      chk("midstart_done_early", 16'(bus.done), 16'd0);
      if (c == 2) begin
        bus.start    = 1'b1;
        bus.dividend = 16'hFEFF;
        bus.divisor  = 8'hFF;
      end
      if (c == 3) bus.start = 1'b0;
      @(posedge clock); #1;
    end
    chk("midstart_done", 16'(bus.done), 16'd1);
    chk("midstart_quotient", 16'(bus.quotient), 16'h4A);
    chk("midstart_remainder", 16'(bus.remainder), 16'h51);

    // Reset in the middle of a run discards the partial result.
    wait_ready("midreset");
    bus.start    = 1'b1;
    bus.dividend = 16'h2783;
    bus.divisor  = 8'h55;
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midreset_state", 16'(dbg_state), 16'(IDLE));
    chk("midreset_ready", 16'(bus.ready), 16'd1);
    chk("midreset_quotient", 16'(bus.quotient), 16'h00);
    chk("midreset_remainder", 16'(bus.remainder), 16'h00);
    chk("midreset_done", 16'(bus.done), 16'd0);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      chk("midreset_no_done", 16'(bus.done), 16'd0);
    end

    // Back-to-back: start held high, second operation accepted straight out of DONE.
    wait_ready("b2b");
    bus.start    = 1'b1;
    bus.dividend = 16'h2783;
    bus.divisor  = 8'h55;
    @(posedge clock); #1;
    exp_q.push_back({8'h77, 8'h00});
    exp_q.push_back({8'h4A, 8'h51});
    bus.dividend = 16'h18E3;
    for (int op = 0; op < 2; op++) begin
      for (int c = 0; c < 8; c++) begin
        chk("b2b_ready_run", 16'(bus.ready), 16'd0);
        chk("b2b_done_early", 16'(bus.done), 16'd0);
        @(posedge clock); #1;
      end
      chk("b2b_done", 16'(bus.done), 16'd1);
      exp_res = exp_q.pop_front();
      chk("b2b_result", {bus.quotient, bus.remainder}, exp_res);
      if (op == 0) begin
        @(posedge clock); #1;
      end
    end
    bus.start = 1'b0;
    @(posedge clock); #1;
    chk("b2b_idle_state", 16'(dbg_state), 16'(IDLE));
    chk("b2b_idle_done", 16'(bus.done), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
